// File: rtl/usb_phy_tx.sv
// USB 1.x transmit PHY: serializes packet bytes as SYNC, NRZI data with bit stuffing, EOP and an
// idle gap. Line level is tracked as "is J"; dp/dm are mapped from it per bus speed.
module usb_phy_tx #(
  parameter int unsigned USB_VER_1_X = 1,
  parameter int unsigned GAP_BITS    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_err_o,
  output logic       usb_tx_dp_o,
  output logic       usb_tx_dm_o,
  output logic       usb_tx_oe_o
);

  localparam int unsigned BitClks = (USB_VER_1_X != 0) ? 2 : 16;
  localparam logic        JDp     = (USB_VER_1_X != 0);
  localparam logic [3:0]  BitLast = 4'(BitClks - 1);
  localparam logic [3:0]  GapLast = 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ, StGap} state_e;

  state_e     state_q;
  logic [3:0] bit_cnt_q;  // clocks within the current symbol
  logic [3:0] bit_num_q;  // bits sent of current byte, or bit times spent in EOP/GAP
  logic [7:0] sh_q;
  logic [2:0] stuff_q;
  logic       last_q;
  logic       line_j_q;
  logic       dp_q, dm_q, oe_q, ready_q, busy_q, err_q;

  logic       boundary, stuff_due, fetch, bit_val, toggle;
  logic       nxt_lvl, nxt_dp;
  logic [2:0] nxt_stuff;

  // Next line symbol if a data or stuff bit is emitted at this boundary.
  always_comb begin
    boundary  = (bit_cnt_q == BitLast);
    stuff_due = (stuff_q == 3'd6);
    fetch     = (bit_num_q == 4'd8);
    bit_val   = fetch ? tx_data_i[0] : sh_q[0];
    toggle    = stuff_due | ~bit_val;
    nxt_lvl   = toggle ? ~line_j_q : line_j_q;
    nxt_stuff = toggle ? 3'd0 : stuff_q + 3'd1;
    nxt_dp    = nxt_lvl ~^ JDp;
  end

  // Packet FSM with bit timer, serializer and registered pad/handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_num_q <= '0;
      sh_q      <= '0;
      stuff_q   <= '0;
      last_q    <= 1'b0;
      line_j_q  <= 1'b1;
      dp_q      <= JDp;
      dm_q      <= ~JDp;
      oe_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == StIdle || boundary) bit_cnt_q <= '0;
      else                               bit_cnt_q <= bit_cnt_q + 4'd1;

      case (state_q)
        StIdle: begin
          if (tx_valid_i) begin
            // SYNC is 8'h80 LSB first; its first bit (0) toggles J to K right away.
            state_q   <= StSync;
            oe_q      <= 1'b1;
            busy_q    <= 1'b1;
            line_j_q  <= 1'b0;
            dp_q      <= ~JDp;
            dm_q      <= JDp;
            stuff_q   <= '0;
            sh_q      <= 8'h40;
            bit_num_q <= 4'd1;
            last_q    <= 1'b0;
          end
        end
        StSync, StData: begin
          if (boundary) begin
            if (stuff_due) begin
              line_j_q <= nxt_lvl;
              dp_q     <= nxt_dp;
              dm_q     <= ~nxt_dp;
              stuff_q  <= 3'd0;
            end else if (fetch && (last_q || !tx_valid_i)) begin
              state_q   <= StEopSe0;
              dp_q      <= 1'b0;
              dm_q      <= 1'b0;
              bit_num_q <= '0;
              err_q     <= ~last_q;
            end else begin
              line_j_q  <= nxt_lvl;
              dp_q      <= nxt_dp;
              dm_q      <= ~nxt_dp;
              stuff_q   <= nxt_stuff;
              if (fetch) begin
                state_q   <= StData;
                ready_q   <= 1'b1;
                sh_q      <= {1'b0, tx_data_i[7:1]};
                last_q    <= tx_last_i;
                bit_num_q <= 4'd1;
              end else begin
                sh_q      <= {1'b0, sh_q[7:1]};
                bit_num_q <= bit_num_q + 4'd1;
              end
            end
          end
        end
        StEopSe0: begin
          if (boundary) begin
            if (bit_num_q == 4'd1) begin
              state_q   <= StEopJ;
              line_j_q  <= 1'b1;
              dp_q      <= JDp;
              dm_q      <= ~JDp;
              bit_num_q <= '0;
            end else begin
              bit_num_q <= bit_num_q + 4'd1;
            end
          end
        end
        StEopJ: begin
          if (boundary) begin
            state_q   <= StGap;
            oe_q      <= 1'b0;
            bit_num_q <= '0;
          end
        end
        StGap: begin
          if (boundary) begin
            if (bit_num_q == GapLast) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              bit_num_q <= bit_num_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready_o  = ready_q;
  assign tx_busy_o   = busy_q;
  assign tx_err_o    = err_q;
  assign usb_tx_dp_o = dp_q;
  assign usb_tx_dm_o = dm_q;
  assign usb_tx_oe_o = oe_q;

endmodule

// File: tb/tb_usb_phy_tx.sv
// Directed bench for usb_phy_tx: full-speed and low-speed instances, line captured as J/K/0 text.
module tb_usb_phy_tx;
  logic       clk;
  logic       rst_n;
  logic       valid_fs, valid_ls;
  logic [7:0] data;
  logic       last;
  logic       fs_ready, fs_busy, fs_err, fs_dp, fs_dm, fs_oe;
  logic       ls_ready, ls_busy, ls_err, ls_dp, ls_dm, ls_oe;

  int checks = 0;
  int errors = 0;

  usb_phy_tx #(.USB_VER_1_X(1), .GAP_BITS(2)) dut_fs (
    .clk_i(clk), .rst_ni(rst_n), .tx_valid_i(valid_fs), .tx_data_i(data), .tx_last_i(last),
    .tx_ready_o(fs_ready), .tx_busy_o(fs_busy), .tx_err_o(fs_err),
    .usb_tx_dp_o(fs_dp), .usb_tx_dm_o(fs_dm), .usb_tx_oe_o(fs_oe)
  );

  usb_phy_tx #(.USB_VER_1_X(0), .GAP_BITS(2)) dut_ls (
    .clk_i(clk), .rst_ni(rst_n), .tx_valid_i(valid_ls), .tx_data_i(data), .tx_last_i(last),
    .tx_ready_o(ls_ready), .tx_busy_o(ls_busy), .tx_err_o(ls_err),
    .usb_tx_dp_o(ls_dp), .usb_tx_dm_o(ls_dm), .usb_tx_oe_o(ls_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: got %s expected %s", tag, obs, exp);
    end
  endtask

  function automatic string sym(input logic dp, input logic dm, input bit ls);
    if (!dp && !dm) return "0";
    if (dp && dm)   return "X";
    if (dp == !ls)  return "J";
    return "K";
  endfunction

  // Starts a packet, feeds bytes on each ready, and records one symbol per bit time while oe=1.
  task automatic run_pkt(input bit ls, input int nbytes, input logic [7:0] b0, input bit l0,
                         input logic [7:0] b1, input bit l1, output string line,
                         output int nready, output int nerr, output int oe_clks,
                         output int tail_clks, output int ready_at, output int err_at,
                         output int nhold);
    int    bc;
    int    pos;
    bit    dropped;
    bit    done;
    logic  dp, dm, oe, rdy, er, bsy;
    string c, prev;
    bc = ls ? 16 : 2;
    line = ""; prev = "";
    nready = 0; nerr = 0; oe_clks = 0; tail_clks = 0; ready_at = -1; err_at = -1; nhold = 0;
    dropped = 0; done = 0;
    data = b0; last = l0;
    if (ls) valid_ls = 1'b1; else valid_fs = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      dp  = ls ? ls_dp : fs_dp;
      dm  = ls ? ls_dm : fs_dm;
      oe  = ls ? ls_oe : fs_oe;
      rdy = ls ? ls_ready : fs_ready;
      er  = ls ? ls_err : fs_err;
      bsy = ls ? ls_busy : fs_busy;
      pos = oe_clks;
      if (!dropped) begin
        if (oe) begin
          c = sym(dp, dm, ls);
          if (oe_clks % bc == 0) begin
            line = {line, c};
            prev = c;
          end else if (c != prev) begin
            nhold++;
          end
          oe_clks++;
        end else if (oe_clks > 0) begin
          dropped = 1;
        end
      end
      if (dropped) begin
        if (bsy) tail_clks++;
        else     done = 1;
      end
      if (rdy) begin
        if (nready == 0) ready_at = pos;
        nready++;
        if (nready == 1 && nbytes > 1) begin
          data = b1; last = l1;
        end
        if (nready >= nbytes) begin
          valid_fs = 1'b0; valid_ls = 1'b0;
        end
      end
      if (er) begin
        if (nerr == 0) err_at = pos;
        nerr++;
      end
    end
    valid_fs = 1'b0; valid_ls = 1'b0;
  endtask

  string line;
  int    nready, nerr, oe_clks, tail, ready_at, err_at, nhold, oe_3c;

  initial begin
    rst_n = 1'b0; valid_fs = 1'b0; valid_ls = 1'b0; data = '0; last = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    check_int("rst_fs_oe", fs_oe, 0);
    check_int("rst_fs_dpdm", {fs_dp, fs_dm}, 2'b10);
    check_int("rst_ls_dpdm", {ls_dp, ls_dm}, 2'b01);
    check_int("rst_flags", {fs_ready, fs_busy, fs_err, ls_busy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: FS ACK
    run_pkt(0, 1, 8'hD2, 1, 8'h00, 0, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("ack_line", line, "KJKJKJKKJJKJJKKK00J");
    check_int("ack_oe_clks", oe_clks, 38);
    check_int("ack_nready", nready, 1);
    check_int("ack_ready_at", ready_at, 16);
    check_int("ack_gap_clks", tail, 4);
    check_int("ack_nerr", nerr, 0);
    check_int("ack_hold", nhold, 0);
    check_int("ack_idle_dpdm", {fs_dp, fs_dm, fs_oe}, 3'b100);

    // 2: FF then 00 with one stuff bit
    run_pkt(0, 2, 8'hFF, 0, 8'h00, 1, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("ff00_line", line, "KJKJKJKKKKKKKJJJJKJKJKJKJ00J");
    check_int("ff00_nready", nready, 2);
    check_int("ff00_oe_clks", oe_clks, 56);

    // 3: trailing six 1s stuffed before EOP; compare with 3C
    run_pkt(0, 1, 8'h3C, 1, 8'h00, 0, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("3c_line", line, "KJKJKJKKJKKKKKJK00J");
    oe_3c = oe_clks;
    run_pkt(0, 1, 8'hFC, 1, 8'h00, 0, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("fc_line", line, "KJKJKJKKJKKKKKKKJ00J");
    check_int("fc_vs_3c_clks", oe_clks - oe_3c, 2);

    // 4: LS ACK
    run_pkt(1, 1, 8'hD2, 1, 8'h00, 0, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("ls_line", line, "KJKJKJKKJJKJJKKK00J");
    check_int("ls_oe_clks", oe_clks, 304);
    check_int("ls_hold", nhold, 0);
    check_int("ls_gap_clks", tail, 32);
    check_int("ls_idle_dpdm", {ls_dp, ls_dm, ls_oe}, 3'b010);

    // 5: underrun after first byte
    run_pkt(0, 1, 8'hC3, 0, 8'h00, 0, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("urun_line", line, "KJKJKJKKKKJKJKKK00J");
    check_int("urun_nerr", nerr, 1);
    check_int("urun_err_at", err_at, 32);
    check_int("urun_nready", nready, 1);

    // 6: reset mid-DATA, then a clean ACK
    data = 8'hFF; last = 1'b0; valid_fs = 1'b1;
    repeat (22) @(negedge clk);
    check_int("pre_rst_oe", fs_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check_int("mid_rst_state", {fs_oe, fs_dp, fs_dm, fs_busy}, 4'b0100);
    valid_fs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_pkt(0, 1, 8'hD2, 1, 8'h00, 0, line, nready, nerr, oe_clks, tail, ready_at, err_at, nhold);
    check_str("post_rst_line", line, "KJKJKJKKJJKJJKKK00J");
    check_int("post_rst_oe_clks", oe_clks, 38);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
